// File: rtl/cache_l1_assoc_ctrl.sv
// Set-associative write-back/write-allocate L1 cache controller with per-set true-LRU
// replacement, processor-ID filtering and saturating hit/miss counters.
module cache_l1_assoc_ctrl #(
    parameter int          NUM_SETS       = 4,
    parameter int          NUM_WAYS       = 2,
    parameter int          WORDS_PER_LINE = 4,
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [1:0]  PROC_ID        = 2'd0,
    localparam int         LINE_WIDTH     = DATA_WIDTH * WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,
    input  logic                  cpu_resp_ready,
    output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic                  cpu_resp_hit,
    output logic                  cpu_resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W - OFF_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, RD_REQ, RD_WAIT, RESPOND} state_e;

    state_e                  state_q, state_d;
    logic                    req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]        victim_q, victim_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_hit_q, resp_hit_d;
    logic                    resp_err_q, resp_err_d;
    logic [31:0]             hit_count_q, hit_count_d;
    logic [31:0]             miss_count_q, miss_count_d;

    logic                    valid_q [NUM_SETS][NUM_WAYS];
    logic                    valid_d [NUM_SETS][NUM_WAYS];
    logic                    dirty_q [NUM_SETS][NUM_WAYS];
    logic                    dirty_d [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]        tag_d   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]        age_q   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]        age_d   [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0]   data_d  [NUM_SETS][NUM_WAYS];

    logic [1:0]              req_id;
    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        req_idx;
    logic [OFF_W-1:0]        req_off;
    logic                    hit_any, inv_any, touch_en;
    logic [WAY_W-1:0]        hit_way, inv_way, lru_way, victim_way, touch_way;
    logic [LINE_WIDTH-1:0]   refill_line;

    assign req_id  = req_addr_q[ADDR_WIDTH-1 -: 2];
    assign req_tag = req_addr_q[ADDR_WIDTH-3 -: TAG_W];
    assign req_idx = req_addr_q[OFF_W +: IDX_W];
    assign req_off = req_addr_q[0 +: OFF_W];

    // Descending scan so the lowest-indexed matching way wins; max age marks the LRU way.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[req_idx][w] == '1) lru_way = WAY_W'(w);
        end
        victim_way = inv_any ? inv_way : lru_way;
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        resp_err_d   = resp_err_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        age_d        = age_q;
        data_d       = data_q;
        touch_en     = 1'b0;
        touch_way    = '0;
        refill_line  = '0;

        case (state_q)
            IDLE: if (cpu_req_valid) begin
                req_write_d = cpu_req_write;
                req_addr_d  = cpu_req_addr;
                req_wdata_d = cpu_req_wdata;
                state_d     = LOOKUP;
            end
            LOOKUP: begin
                if (req_id != PROC_ID) begin
                    resp_rdata_d = '0;
                    resp_hit_d   = 1'b0;
                    resp_err_d   = 1'b1;
                    state_d      = RESPOND;
                end else if (hit_any) begin
                    resp_err_d   = 1'b0;
                    resp_hit_d   = 1'b1;
                    resp_rdata_d = req_write_q ? '0 :
                        data_q[req_idx][hit_way][int'(req_off)*DATA_WIDTH +: DATA_WIDTH];
                    if (req_write_q) begin
                        data_d[req_idx][hit_way][int'(req_off)*DATA_WIDTH +: DATA_WIDTH] = req_wdata_q;
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                    touch_en  = 1'b1;
                    touch_way = hit_way;
                    if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
                    state_d = RESPOND;
                end else begin
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
                    victim_d = victim_way;
                    state_d  = (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way])
                               ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: if (mem_req_ready) begin
                dirty_d[req_idx][victim_q] = 1'b0;
                state_d = RD_REQ;
            end
            RD_REQ: if (mem_req_ready) state_d = RD_WAIT;
            RD_WAIT: if (mem_resp_valid) begin
                refill_line  = mem_resp_rdata;
                resp_rdata_d = req_write_q ? '0 :
                    mem_resp_rdata[int'(req_off)*DATA_WIDTH +: DATA_WIDTH];
                if (req_write_q) refill_line[int'(req_off)*DATA_WIDTH +: DATA_WIDTH] = req_wdata_q;
                data_d[req_idx][victim_q]  = refill_line;
                valid_d[req_idx][victim_q] = 1'b1;
                tag_d[req_idx][victim_q]   = req_tag;
                dirty_d[req_idx][victim_q] = req_write_q;
                resp_hit_d = 1'b0;
                resp_err_d = 1'b0;
                touch_en   = 1'b1;
                touch_way  = victim_q;
                state_d    = RESPOND;
            end
            RESPOND: if (cpu_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (touch_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age_d[req_idx][w] = '0;
                else if (age_q[req_idx][w] < age_q[req_idx][touch_way])
                    age_d[req_idx][w] = age_q[req_idx][w] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            victim_q     <= '0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q      <= state_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            victim_q     <= victim_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            resp_err_q   <= resp_err_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            tag_q        <= tag_d;
            age_q        <= age_d;
        end
    end

    // NOTE: line data is not reset; it is only ever observed behind a valid bit.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_comb begin
        cpu_req_ready  = (state_q == IDLE);
        cpu_resp_valid = (state_q == RESPOND);
        cpu_resp_rdata = resp_rdata_q;
        cpu_resp_hit   = resp_hit_q;
        cpu_resp_err   = resp_err_q;
        mem_req_valid  = 1'b0;
        mem_req_write  = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        if (state_q == WB_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = {PROC_ID, tag_q[req_idx][victim_q], req_idx, {OFF_W{1'b0}}};
            mem_req_wdata = data_q[req_idx][victim_q];
        end else if (state_q == RD_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {PROC_ID, req_tag, req_idx, {OFF_W{1'b0}}};
        end
        hit_count  = hit_count_q;
        miss_count = miss_count_q;
    end

endmodule

// File: tb/tb_cache_l1_assoc_ctrl.sv
// Scoreboard bench for cache_l1_assoc_ctrl: expected responses and lower-level requests
// are queued when a request is issued and compared as the controller produces them.
module tb_cache_l1_assoc_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 128;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] refill;
    } mem_exp_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          hit;
        logic          err;
    } resp_exp_t;

    logic          clk;
    logic          reset;
    logic          cpu_req_valid, cpu_req_ready, cpu_req_write;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_resp_valid, cpu_resp_ready;
    logic [DW-1:0] cpu_resp_rdata;
    logic          cpu_resp_hit, cpu_resp_err;
    logic          mem_req_valid, mem_req_ready, mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [LW-1:0] mem_resp_rdata;
    logic [31:0]   hit_count, miss_count;

    int checks;
    int failures;
    int exp_hits;
    int exp_misses;
    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    localparam logic [LW-1:0] L1 = 128'h00004444_00003333_00002222_00001111;
    localparam logic [LW-1:0] L2 = 128'h2D2D2D2D_2C2C2C2C_2B2B2B2B_2A2A2A2A;
    localparam logic [LW-1:0] L3 = 128'h3D3D3D3D_3C3C3C3C_3B3B3B3B_3A3A3A3A;
    localparam logic [LW-1:0] L4 = 128'h4D4D4D4D_4C4C4C4C_4B4B4B4B_4A4A4A4A;

    cache_l1_assoc_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_write  (cpu_req_write),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_ready (cpu_resp_ready),
        .cpu_resp_rdata (cpu_resp_rdata),
        .cpu_resp_hit   (cpu_resp_hit),
        .cpu_resp_err   (cpu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] put_word(input logic [LW-1:0] line, input int off,
                                               input logic [DW-1:0] w);
        logic [LW-1:0] l;
        l = line;
        l[off*DW +: DW] = w;
        return l;
    endfunction

    function automatic logic [DW-1:0] get_word(input logic [LW-1:0] line, input int off);
        return line[off*DW +: DW];
    endfunction

    task automatic expect_mem(input logic wr, input logic [AW-1:0] addr,
                              input logic [LW-1:0] wdata, input logic [LW-1:0] refill);
        mem_exp_t m;
        m.write  = wr;
        m.addr   = addr;
        m.wdata  = wdata;
        m.refill = refill;
        mem_q.push_back(m);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        cpu_req_valid  = 1'b0;
        cpu_req_write  = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_wdata  = '0;
        cpu_resp_ready = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_q.delete();
        resp_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_wdata", mem_req_wdata, 0);
        check("rst_resp_valid", cpu_resp_valid, 0);
        check("rst_resp_rdata", cpu_resp_rdata, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", cpu_req_ready, 1);
    endtask

    // Issue one request and service the lower level until the response is taken.
    task automatic transact(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] exp_rdata, input logic exp_hit, input logic exp_err,
                            input int wb_stall, input int resp_stall);
        resp_exp_t     r;
        mem_exp_t      m;
        bit            have_m, refill_pend, done;
        int            stall;
        logic [LW-1:0] refill_line;
        r.rdata = exp_rdata;
        r.hit   = exp_hit;
        r.err   = exp_err;
        resp_q.push_back(r);
        m.write = 1'b0; m.addr = '0; m.wdata = '0; m.refill = '0;
        have_m = 0; refill_pend = 0; done = 0; stall = 0; refill_line = '0;

        @(negedge clk);
        check("req_ready", cpu_req_ready, 1);
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_write = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;

        for (int k = 1; k <= 200 && !done; k++) begin
            if (k > 1) @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            if (refill_pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = refill_line;
                refill_pend    = 0;
            end
            if (cpu_resp_valid) begin
                r = resp_q.pop_front();
                check("resp_rdata", cpu_resp_rdata, r.rdata);
                check("resp_hit", cpu_resp_hit, r.hit);
                check("resp_err", cpu_resp_err, r.err);
                if (r.hit) check("hit_latency", k, 2);
                for (int s = 0; s < resp_stall; s++) begin
                    cpu_req_valid = 1'b1;
                    cpu_req_addr  = 32'h0000_0050;
                    @(negedge clk);
                    check("hold_resp_valid", cpu_resp_valid, 1);
                    check("hold_resp_rdata", cpu_resp_rdata, r.rdata);
                    check("hold_req_ready", cpu_req_ready, 0);
                end
                cpu_req_valid  = 1'b0;
                cpu_req_addr   = '0;
                cpu_resp_ready = 1'b1;
                @(negedge clk);
                cpu_resp_ready = 1'b0;
                check("resp_drop", cpu_resp_valid, 0);
                check("back_to_idle", cpu_req_ready, 1);
                done = 1;
            end else if (mem_req_valid) begin
                if (!have_m) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected", 1, 0);
                        m.write = 1'b0; m.addr = '0; m.wdata = '0; m.refill = '0;
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_write", mem_req_write, m.write);
                        check("mem_addr", mem_req_addr, m.addr);
                        check("mem_wdata", mem_req_wdata, m.wdata);
                    end
                    have_m = 1;
                    stall  = m.write ? wb_stall : 0;
                end else begin
                    check("mem_stable_write", mem_req_write, m.write);
                    check("mem_stable_addr", mem_req_addr, m.addr);
                    check("mem_stable_wdata", mem_req_wdata, m.wdata);
                end
                if (stall == 0) begin
                    mem_req_ready = 1'b1;
                    have_m        = 0;
                    if (!m.write) begin
                        refill_pend = 1;
                        refill_line = m.refill;
                    end
                end else begin
                    stall--;
                end
            end
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (!done) check("timeout", 0, 1);
        check("mem_all_seen", mem_q.size(), 0);
        if (!exp_err) begin
            if (exp_hit) exp_hits++;
            else exp_misses++;
        end
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Basic miss/hit, write hit, foreign processor ID, second set.
        do_reset();
        expect_mem(0, 32'h10, '0, L1);
        transact(0, 32'h10, '0, 32'h1111, 0, 0, 0, 0);
        transact(0, 32'h11, '0, 32'h2222, 1, 0, 0, 0);
        transact(1, 32'h13, 32'hCAFE_0000, '0, 1, 0, 0, 0);
        transact(0, 32'h13, '0, 32'hCAFE_0000, 1, 0, 0, 0);
        transact(0, 32'h4000_0010, '0, '0, 0, 1, 0, 0);
        expect_mem(0, 32'h14, '0, L4);
        transact(0, 32'h17, '0, get_word(L4, 3), 0, 0, 0, 0);

        // Dirty eviction with a stalled write-back and a stalled response.
        do_reset();
        expect_mem(0, 32'h20, '0, L2);
        transact(1, 32'h22, 32'hDEAD_BEEF, '0, 0, 0, 0, 0);
        expect_mem(0, 32'h10, '0, L1);
        transact(0, 32'h11, '0, 32'h2222, 0, 0, 0, 0);
        expect_mem(1, 32'h20, put_word(L2, 2, 32'hDEAD_BEEF), '0);
        expect_mem(0, 32'h30, '0, L3);
        transact(0, 32'h33, '0, get_word(L3, 3), 0, 0, 5, 3);
        expect_mem(0, 32'h20, '0, put_word(L2, 2, 32'hDEAD_BEEF));
        transact(0, 32'h22, '0, 32'hDEAD_BEEF, 0, 0, 0, 0);

        // LRU ordering: tag 2 becomes least recent and is replaced without write-back.
        do_reset();
        expect_mem(0, 32'h10, '0, L1);
        transact(0, 32'h10, '0, 32'h1111, 0, 0, 0, 0);
        expect_mem(0, 32'h20, '0, L2);
        transact(0, 32'h21, '0, get_word(L2, 1), 0, 0, 0, 0);
        transact(0, 32'h12, '0, 32'h3333, 1, 0, 0, 0);
        expect_mem(0, 32'h30, '0, L3);
        transact(0, 32'h30, '0, get_word(L3, 0), 0, 0, 0, 0);
        transact(0, 32'h13, '0, 32'h4444, 1, 0, 0, 0);
        expect_mem(0, 32'h20, '0, L2);
        transact(0, 32'h20, '0, get_word(L2, 0), 0, 0, 0, 0);

        // Reset while a line read is being requested.
        do_reset();
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h10;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        @(negedge clk);
        check("rdreq_valid", mem_req_valid, 1);
        check("rdreq_miss_pre", miss_count, 1);
        #2 reset = 1'b0;
        #1 check("rdreq_rst_drop", mem_req_valid, 0);
        check("rdreq_rst_miss", miss_count, 0);

        // Reset while waiting for refill data.
        do_reset();
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h10;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        @(negedge clk);
        check("rdwait_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rdwait_no_req", mem_req_valid, 0);
        check("rdwait_busy", cpu_req_ready, 0);
        #2 reset = 1'b0;
        #1 check("rdwait_rst_mem", mem_req_valid, 0);
        check("rdwait_rst_miss", miss_count, 0);
        check("rdwait_rst_resp", cpu_resp_valid, 0);
        do_reset();
        expect_mem(0, 32'h10, '0, L1);
        transact(0, 32'h11, '0, 32'h2222, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
